// File: rtl/pattern_seq_pkg.sv
// Shared definitions for the pattern vector sequencer: opcodes, FSM states and vector-word layout.
// Vector word, MSB first: {opcode, repeat, wft, wfc}, with wfc starting at bit 0.
package pattern_seq_pkg;

  localparam int unsigned OpcodeW   = 2;
  localparam int unsigned RepeatW   = 16;
  localparam int unsigned MinPeriod = 2;

  typedef enum logic [OpcodeW-1:0] {
    OpNormal    = 2'd0,
    OpLoopStart = 2'd1,
    OpLoopEnd   = 2'd2,
    OpHalt      = 2'd3
  } opcode_e;

  typedef enum logic [1:0] {
    StIdle,
    StPrime,
    StRun,
    StDone
  } seq_state_e;

  function automatic int unsigned wfc_lsb();
    return 0;
  endfunction

  function automatic int unsigned wft_lsb(input int unsigned wfc_w);
    return wfc_w;
  endfunction

  function automatic int unsigned rep_lsb(input int unsigned wft_w, input int unsigned wfc_w);
    return wfc_w + wft_w;
  endfunction

  function automatic int unsigned op_lsb(input int unsigned wft_w, input int unsigned wfc_w);
    return wfc_w + wft_w + RepeatW;
  endfunction

endpackage

// File: rtl/pattern_cycle_timer.sv
// Tester-cycle timer: counts clocks inside a tester cycle, flags each boundary and
// registers tester_sync for boundaries at which a vector is actually applied.
module pattern_cycle_timer (
  input  logic       clock,
  input  logic       reset,
  input  logic       run,
  input  logic [7:0] period,
  input  logic       fire,
  output logic       tick,
  output logic       tester_sync
);

  logic [7:0] cnt_q, cnt_d;
  logic       sync_q;

  // tick means the next clock edge opens a new tester cycle.
  assign tick = run && (cnt_q == 8'd0);

  always_comb begin
    cnt_d = 8'd0;
    if (run && (cnt_q != period - 8'd1)) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q  <= 8'd0;
      sync_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sync_q <= tick && fire;
    end
  end

  assign tester_sync = sync_q;

endmodule

// File: rtl/pattern_vector_sequencer.sv
// Pattern vector sequencer: fetches vector words one ahead and applies them per tester cycle.
// Define VTW_LOOP_EN to enable single-level LOOP_START/LOOP_END handling.
module pattern_vector_sequencer
  import pattern_seq_pkg::*;
#(
  parameter int unsigned NUM_PINS    = 23,
  parameter int unsigned WFC_PER_PIN = 8,
  parameter int unsigned WFT_W       = 4,
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned INT_W       = 32
) (
  input  logic                                             clock,
  input  logic                                             reset,
  input  logic                                             start,
  input  logic                                             abort,
  input  logic [ADDR_W-1:0]                                start_addr,
  input  logic [7:0]                                       period,
  output logic                                             mem_rd,
  output logic [ADDR_W-1:0]                                mem_addr,
  input  logic [OpcodeW+RepeatW+WFT_W+NUM_PINS*WFC_PER_PIN-1:0] mem_rdata,
  output logic                                             tester_sync,
  output logic [WFT_W-1:0]                                 wft,
  output logic [NUM_PINS*WFC_PER_PIN-1:0]                  wfc,
  output logic [INT_W-1:0]                                 vector_number,
  output logic [INT_W-1:0]                                 cycle_number,
  output logic                                             busy,
  output logic                                             done
);

  localparam int unsigned WfcW  = NUM_PINS * WFC_PER_PIN;
  localparam int unsigned WordW = OpcodeW + RepeatW + WFT_W + WfcW;
  localparam int unsigned WfcLsb = wfc_lsb();
  localparam int unsigned WftLsb = wft_lsb(WfcW);
  localparam int unsigned RepLsb = rep_lsb(WFT_W, WfcW);
  localparam int unsigned OpLsb  = op_lsb(WFT_W, WfcW);

  seq_state_e         state_q, state_d;
  logic [7:0]         period_q, period_d;
  logic               mem_rd_q, mem_rd_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic               rvalid_q, rvalid_d;
  logic [WordW-1:0]   pf_q, pf_d;
  logic [WFT_W-1:0]   wft_q, wft_d;
  logic [WfcW-1:0]    wfc_q, wfc_d;
  logic [INT_W-1:0]   vn_q, vn_d;
  logic [INT_W-1:0]   cn_q, cn_d;
  logic [RepeatW-1:0] cur_rep_q, cur_rep_d;
  logic               first_q, first_d;
  logic               done_q, done_d;

`ifdef VTW_LOOP_EN
  logic [ADDR_W-1:0]  loop_addr_q, loop_addr_d;
  logic [RepeatW-1:0] loop_cnt_q, loop_cnt_d;
`endif

  logic               tick;
  logic               apply;
  logic               fetch;
  logic [ADDR_W-1:0]  fetch_addr;
  logic [ADDR_W-1:0]  next_addr;
  logic [WordW-1:0]   nw;
  opcode_e            nw_op;
  logic [RepeatW-1:0] nw_rep;
  logic [WFT_W-1:0]   nw_wft;
  logic [WfcW-1:0]    nw_wfc;

  // With P=2 the next word arrives on the boundary clock itself, so bypass the prefetch reg.
  assign nw        = rvalid_q ? mem_rdata : pf_q;
  assign nw_op     = opcode_e'(nw[OpLsb +: OpcodeW]);
  assign nw_rep    = nw[RepLsb +: RepeatW];
  assign nw_wft    = nw[WftLsb +: WFT_W];
  assign nw_wfc    = nw[WfcLsb +: WfcW];
  assign next_addr = mem_addr_q + ADDR_W'(1);

  pattern_cycle_timer u_timer (
    .clock       (clock),
    .reset       (reset),
    .run         (state_q == StRun),
    .period      (period_q),
    .fire        (apply),
    .tick        (tick),
    .tester_sync (tester_sync)
  );

  always_comb begin
    state_d    = state_q;
    period_d   = period_q;
    mem_rd_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    rvalid_d   = mem_rd_q;
    pf_d       = pf_q;
    wft_d      = wft_q;
    wfc_d      = wfc_q;
    vn_d       = vn_q;
    cn_d       = cn_q;
    cur_rep_d  = cur_rep_q;
    first_d    = first_q;
    done_d     = 1'b0;
    apply      = 1'b0;
    fetch      = 1'b0;
    fetch_addr = next_addr;
`ifdef VTW_LOOP_EN
    loop_addr_d = loop_addr_q;
    loop_cnt_d  = loop_cnt_q;
`endif

    if (rvalid_q) begin
      pf_d = mem_rdata;
    end

    if (abort) begin
      state_d  = StIdle;
      rvalid_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_d    = StPrime;
            period_d   = (period < 8'(MinPeriod)) ? 8'(MinPeriod) : period;
            fetch      = 1'b1;
            fetch_addr = start_addr;
            first_d    = 1'b1;
            cur_rep_d  = '0;
          end
        end
        StPrime: begin
          if (rvalid_q) begin
            state_d = StRun;
          end
        end
        StRun: begin
          if (tick) begin
            if (cur_rep_q != '0) begin
              apply     = 1'b1;
              cn_d      = cn_q + INT_W'(1);
              cur_rep_d = cur_rep_q - RepeatW'(1);
              fetch     = (cur_rep_q == RepeatW'(1));
            end else if (nw_op == OpHalt) begin
              state_d = StDone;
              done_d  = 1'b1;
            end else begin
              apply     = 1'b1;
              wft_d     = nw_wft;
              wfc_d     = nw_wfc;
              first_d   = 1'b0;
              vn_d      = first_q ? '0 : vn_q + INT_W'(1);
              cn_d      = first_q ? '0 : cn_q + INT_W'(1);
              cur_rep_d = nw_rep;
              fetch     = (nw_rep == '0);
`ifdef VTW_LOOP_EN
              // Loop markers are applied once; their repeat field is the loop count.
              if (nw_op == OpLoopStart) begin
                loop_addr_d = next_addr;
                loop_cnt_d  = nw_rep;
                cur_rep_d   = '0;
                fetch       = 1'b1;
              end else if (nw_op == OpLoopEnd) begin
                cur_rep_d = '0;
                fetch     = 1'b1;
                if (loop_cnt_q != '0) begin
                  loop_cnt_d = loop_cnt_q - RepeatW'(1);
                  fetch_addr = loop_addr_q;
                end
              end
`endif
            end
          end
        end
        StDone: begin
          state_d = StIdle;
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end

    if (fetch) begin
      mem_rd_d   = 1'b1;
      mem_addr_d = fetch_addr;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      period_q   <= 8'(MinPeriod);
      mem_rd_q   <= 1'b0;
      mem_addr_q <= '0;
      rvalid_q   <= 1'b0;
      pf_q       <= '0;
      wft_q      <= '0;
      wfc_q      <= '0;
      vn_q       <= '0;
      cn_q       <= '0;
      cur_rep_q  <= '0;
      first_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      period_q   <= period_d;
      mem_rd_q   <= mem_rd_d;
      mem_addr_q <= mem_addr_d;
      rvalid_q   <= rvalid_d;
      pf_q       <= pf_d;
      wft_q      <= wft_d;
      wfc_q      <= wfc_d;
      vn_q       <= vn_d;
      cn_q       <= cn_d;
      cur_rep_q  <= cur_rep_d;
      first_q    <= first_d;
      done_q     <= done_d;
    end
  end

`ifdef VTW_LOOP_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      loop_addr_q <= '0;
      loop_cnt_q  <= '0;
    end else begin
      loop_addr_q <= loop_addr_d;
      loop_cnt_q  <= loop_cnt_d;
    end
  end
`endif

  assign mem_rd        = mem_rd_q;
  assign mem_addr      = mem_addr_q;
  assign wft           = wft_q;
  assign wfc           = wfc_q;
  assign vector_number = vn_q;
  assign cycle_number  = cn_q;
  assign busy          = (state_q != StIdle);
  assign done          = done_q;

endmodule

// File: tb/tb_pattern_vector_sequencer.sv
// Self-checking bench for pattern_vector_sequencer: program-walking reference model plus
// directed programs with hand-computed pins.
module tb_pattern_vector_sequencer;

  localparam int NP   = 23;
  localparam int WFTW = 4;
  localparam int AW   = 16;
  localparam int IW   = 32;
  localparam int WFCW = NP * 8;
  localparam int WW   = 2 + 16 + WFTW + WFCW;
`ifdef VTW_LOOP_EN
  localparam bit LoopEn = 1'b1;
`else
  localparam bit LoopEn = 1'b0;
`endif

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic            start = 1'b0;
  logic            abort = 1'b0;
  logic [AW-1:0]   start_addr = '0;
  logic [7:0]      period = '0;
  logic            mem_rd;
  logic [AW-1:0]   mem_addr;
  logic [WW-1:0]   mem_rdata;
  logic            tester_sync;
  logic [WFTW-1:0] wft;
  logic [WFCW-1:0] wfc;
  logic [IW-1:0]   vector_number;
  logic [IW-1:0]   cycle_number;
  logic            busy;
  logic            done;

  pattern_vector_sequencer dut (
    .clock         (clock),
    .reset         (reset),
    .start         (start),
    .abort         (abort),
    .start_addr    (start_addr),
    .period        (period),
    .mem_rd        (mem_rd),
    .mem_addr      (mem_addr),
    .mem_rdata     (mem_rdata),
    .tester_sync   (tester_sync),
    .wft           (wft),
    .wfc           (wfc),
    .vector_number (vector_number),
    .cycle_number  (cycle_number),
    .busy          (busy),
    .done          (done)
  );

  always #5 clock = ~clock;

  // Vector memory: data valid exactly one clock after mem_rd, garbage otherwise.
  logic [WW-1:0] mem [256];
  always @(posedge clock) mem_rdata <= mem_rd ? mem[mem_addr[7:0]] : {WW{1'b1}};

  typedef struct packed {
    logic [WFTW-1:0] wft;
    logic [WFCW-1:0] wfc;
    logic [IW-1:0]   vn;
    logic [IW-1:0]   cn;
  } exp_t;

  exp_t          exp_q[$];
  logic [AW-1:0] rd_q[$];
  exp_t          cur;
  bit            have_cur = 1'b0;
  bit            chk_en = 1'b0;
  int            n_tests = 0, n_fail = 0;
  int            cyc = 0, exp_p = 2, exp_total = 0, rd_total = 0;
  int            sync_count = 0, rd_count = 0, done_count = 0, last_sync_t = 0, done_t = 0;

  function automatic void chk(input string nm, input logic [255:0] act, input logic [255:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    end
  endfunction

  function automatic logic [WW-1:0] mk(input int op, input int rep, input int wv, input int seed);
    logic [WFCW-1:0] w;
    for (int i = 0; i < NP; i++) w[i*8 +: 8] = 8'(seed + i * 7);
    return {2'(op), 16'(rep), 4'(wv), w};
  endfunction

  function automatic exp_t mk_exp(input logic [WW-1:0] w, input int vn, input int cn);
    exp_t e;
    e.wft = w[WFCW +: WFTW];
    e.wfc = w[WFCW-1:0];
    e.vn  = IW'(vn);
    e.cn  = IW'(cn);
    return e;
  endfunction

  // Walk the program from the start address: every fetched address and every applied cycle.
  task automatic build_model(input logic [AW-1:0] sa);
    logic [AW-1:0] a, la;
    logic [WW-1:0] w;
    int lc, vn, cn, op, rep;
    exp_q.delete();
    rd_q.delete();
    a = sa; la = '0; lc = 0; vn = 0; cn = 0;
    for (int g = 0; g < 64; g++) begin
      rd_q.push_back(a);
      w   = mem[a[7:0]];
      op  = int'(w[WW-1 -: 2]);
      rep = int'(w[WW-3 -: 16]);
      if (op == 3) break;
      if (LoopEn && op == 1) begin
        exp_q.push_back(mk_exp(w, vn, cn)); cn++;
        la = a + 16'd1; lc = rep; a = a + 16'd1;
      end else if (LoopEn && op == 2) begin
        exp_q.push_back(mk_exp(w, vn, cn)); cn++;
        if (lc > 0) begin lc--; a = la; end else a = a + 16'd1;
      end else begin
        for (int r = 0; r <= rep; r++) begin exp_q.push_back(mk_exp(w, vn, cn)); cn++; end
        a = a + 16'd1;
      end
      vn++;
    end
  endtask

  initial forever begin
    @(negedge clock);
    if (chk_en) begin
      if (tester_sync) begin
        sync_count++;
        if (exp_q.size() > 0) begin
          cur = exp_q.pop_front();
          if (have_cur) chk("sync_gap", 256'(cyc - last_sync_t), 256'(exp_p));
          have_cur = 1'b1;
          chk("apply", 256'({wft, wfc, vector_number, cycle_number}), 256'(cur));
        end
        last_sync_t = cyc;
      end else if (have_cur) begin
        chk("hold", 256'({wft, wfc, vector_number, cycle_number}), 256'(cur));
      end
      if (mem_rd) begin
        rd_count++;
        if (rd_q.size() > 0) chk("rd_addr", 256'(mem_addr), 256'(rd_q.pop_front()));
      end
      if (done) begin
        done_count++;
        done_t = cyc;
      end
    end
    cyc++;
  end

  task automatic start_prog(input logic [AW-1:0] sa, input logic [7:0] per);
    build_model(sa);
    exp_total = exp_q.size();
    rd_total  = rd_q.size();
    exp_p     = (per < 8'd2) ? 2 : int'(per);
    sync_count = 0; rd_count = 0; done_count = 0; have_cur = 1'b0;
    @(negedge clock);
    chk_en = 1'b1;
    start_addr = sa;
    period = per;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic finish_prog();
    for (int i = 0; i < 3000 && done_count == 0; i++) @(negedge clock);
    repeat (4) @(negedge clock);
    chk("done_count", 256'(done_count), 256'(1));
    chk("sync_count", 256'(sync_count), 256'(exp_total));
    chk("rd_count", 256'(rd_count), 256'(rd_total));
    if (sync_count > 0) chk("done_latency", 256'(done_t - last_sync_t), 256'(exp_p));
    chk("busy_after", 256'(busy), 256'(0));
    chk_en = 1'b0;
  endtask

  task automatic chk_all_zero(input string nm);
    chk(nm, 256'({mem_rd, mem_addr, tester_sync, wft, wfc, vector_number, cycle_number,
                  busy, done}), 256'(0));
  endtask

  initial begin
    exp_t  snap_ok;
    int    bad;
    for (int i = 0; i < 256; i++) mem[i] = mk(3, 0, 15, i);
    mem[64] = mk(0, 2, 1, 11);   mem[65] = mk(3, 0, 0, 0);
    mem[16] = mk(0, 0, 2, 21);   mem[17] = mk(0, 0, 3, 31);
    mem[18] = mk(0, 0, 4, 41);   mem[19] = mk(3, 0, 0, 0);
    mem[32] = mk(1, 1, 5, 51);   mem[33] = mk(0, 0, 6, 61);
    mem[34] = mk(2, 0, 7, 71);   mem[35] = mk(3, 0, 0, 0);
    mem[48] = mk(0, 1, 8, 81);   mem[49] = mk(0, 0, 9, 91);
    mem[50] = mk(0, 3, 10, 101); mem[51] = mk(3, 0, 0, 0);
    mem[255] = mk(0, 1, 11, 111); mem[0] = mk(0, 0, 12, 121); mem[1] = mk(3, 0, 0, 0);
    mem[80] = mk(0, 20, 13, 131); mem[81] = mk(3, 0, 0, 0);

    #1;
    chk_all_zero("reset_outputs");
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk_all_zero("idle_outputs");

    // Period 4, one vector repeated three times.
    start_prog(16'd64, 8'd4);
    finish_prog();
    chk("t1_model_len", 256'(exp_total), 256'(3));
    chk("t1_syncs", 256'(sync_count), 256'(3));
    chk("t1_cycle_number", 256'(cycle_number), 256'(2));
    chk("t1_vector_number", 256'(vector_number), 256'(0));
    chk("t1_wft", 256'(wft), 256'(1));

    // Period 0 and 1 clamp to 2.
    start_prog(16'd16, 8'd0);
    finish_prog();
    chk("clamp0_syncs", 256'(sync_count), 256'(3));
    chk("clamp0_vector_number", 256'(vector_number), 256'(2));
    start_prog(16'd16, 8'd1);
    finish_prog();
    chk("clamp1_cycle_number", 256'(cycle_number), 256'(2));

    // Loop program.
    start_prog(16'd32, 8'd3);
    finish_prog();
`ifdef VTW_LOOP_EN
    chk("loop_syncs", 256'(sync_count), 256'(5));
    chk("loop_vector_number", 256'(vector_number), 256'(4));
    chk("loop_cycle_number", 256'(cycle_number), 256'(4));
    chk("loop_wft", 256'(wft), 256'(7));
`else
    chk("noloop_syncs", 256'(sync_count), 256'(4));
    chk("noloop_vector_number", 256'(vector_number), 256'(2));
    chk("noloop_cycle_number", 256'(cycle_number), 256'(3));
`endif

    // Mixed repeats at the minimum period.
    start_prog(16'd48, 8'd2);
    finish_prog();
    chk("mixed_cycle_number", 256'(cycle_number), 256'(6));
    chk("mixed_vector_number", 256'(vector_number), 256'(2));

    // Address wrap from 0xFFFF to 0x0000.
    start_prog(16'hFFFF, 8'd5);
    finish_prog();
    chk("wrap_wft", 256'(wft), 256'(12));
    chk("wrap_cycle_number", 256'(cycle_number), 256'(2));

    // Abort mid tester cycle.
    start_prog(16'd80, 8'd6);
    for (int i = 0; i < 500 && sync_count < 2; i++) @(negedge clock);
    @(negedge clock);
    @(negedge clock);
    abort = 1'b1;
    @(posedge clock);
    #1;
    abort = 1'b0;
    chk_en = 1'b0;
    chk("abort_busy", 256'(busy), 256'(0));
    snap_ok = cur;
    bad = 0;
    repeat (20) begin
      @(negedge clock);
      if (tester_sync || done || busy) bad++;
    end
    chk("abort_quiet", 256'(bad), 256'(0));
    chk("abort_frozen", 256'({wft, wfc, vector_number, cycle_number}), 256'(snap_ok));
    chk("abort_cycle_number", 256'(cycle_number), 256'(1));

    // abort and start together in IDLE: abort wins.
    @(negedge clock);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clock);
    start = 1'b0;
    abort = 1'b0;
    chk("abort_start_busy", 256'(busy), 256'(0));
    repeat (3) @(negedge clock);
    chk("abort_start_no_rd", 256'({busy, mem_rd}), 256'(0));

    // Asynchronous reset mid-run, then a clean restart.
    start_prog(16'd64, 8'd4);
    for (int i = 0; i < 500 && sync_count < 2; i++) @(negedge clock);
    #2;
    reset = 1'b0;
    chk_en = 1'b0;
    #1;
    chk_all_zero("async_reset");
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    chk("post_reset_busy", 256'(busy), 256'(0));
    start_prog(16'd64, 8'd4);
    finish_prog();
    chk("restart_cycle_number", 256'(cycle_number), 256'(2));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1);
  end

endmodule
